pim_regfile_seq: RTL and testbench

Parametrised, sequenced successor to the processor's in-array register file. Holds `NREGS` architectural registers plus `NBUF` scratch buffer rows. Executes a requested operation on two registers (or register and immediate) inside the array over one or more cycles, then writes the result back to `rd`. It sits between the decode/control stage and memory: it takes operation requests over a valid/ready handshake, provides two combinational read ports for store data and address, and accepts load writebacks on a separate port.

---
 rtl/pim_pkg.sv | 37 +++
 rtl/pim_row_alu.sv | 37 +++
 rtl/pim_regfile_seq.sv | 201 ++++++++++++++++++++
 tb/tb_pim_regfile_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_pkg.sv
// Shared types for the sequenced in-array register file: operation codes,
// sequencer states, row-ALU micro-operations and buffer-row indices.
package pim_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_LUI = 4'd7,
        OP_EQ  = 4'd8
    } pim_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } pim_state_t;

    typedef enum logic [2:0] {
        ROW_AND = 3'd0,
        ROW_OR  = 3'd1,
        ROW_XOR = 3'd2,
        ROW_ADD = 3'd3,
        ROW_INV = 3'd4,
        ROW_SLL = 3'd5,
        ROW_SRL = 3'd6
    } row_op_t;

    localparam int BUF_A = 0;
    localparam int BUF_B = 1;

endpackage

// File: rtl/pim_row_alu.sv
// One-cycle row operation across two buffer rows; cout is the adder carry
// or the single bit shifted out, zero for the bitwise operations.
module pim_row_alu
    import pim_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  row_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            cin,
    output logic [XLEN-1:0] y,
    output logic            cout
);

    always_comb begin
        y    = '0;
        cout = 1'b0;
        case (op)
            ROW_AND: y = a & b;
            ROW_OR:  y = a | b;
            ROW_XOR: y = a ^ b;
            ROW_ADD: {cout, y} = {1'b0, a} + {1'b0, b} + {{XLEN{1'b0}}, cin};
            ROW_INV: y = ~b;
            ROW_SLL: begin
                y    = {a[XLEN-2:0], 1'b0};
                cout = a[XLEN-1];
            end
            ROW_SRL: begin
                y    = {1'b0, a[XLEN-1:1]};
                cout = a[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pim_regfile_seq.sv
// Register file that executes ALU requests inside the array through two
// buffer rows, sequenced IDLE -> LOAD -> EXEC (N cycles) -> WB.
module pim_regfile_seq
    import pim_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NBUF  = 2,
    parameter int IW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  pim_op_t         req_op,
    input  logic [IW-1:0]   req_rd,
    input  logic [IW-1:0]   req_rs1,
    input  logic [IW-1:0]   req_rs2,
    input  logic [XLEN-1:0] req_imm,
    input  logic            req_imm_sel,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_result,
    output logic            resp_carry,
    output logic            resp_eq,
    input  logic            ld_valid,
    input  logic [IW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    input  logic [IW-1:0]   rp_a_idx,
    input  logic [IW-1:0]   rp_b_idx,
    output logic [XLEN-1:0] rp_a_data,
    output logic [XLEN-1:0] rp_b_data
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] rf_q  [NREGS];
    logic [XLEN-1:0] buf_q [NBUF];

    pim_state_t      state_q, state_d;
    pim_op_t         op_q;
    logic [IW-1:0]   rd_q, rs1_q, rs2_q;
    logic [XLEN-1:0] imm_q;
    logic            imm_sel_q;
    logic [SHW-1:0]  cnt_q;
    logic [SHW-1:0]  shamt;

    row_op_t         alu_op;
    logic            alu_cin;
    logic [XLEN-1:0] alu_y;
    logic            alu_cout;
    logic            exec_last;
    logic [XLEN-1:0] fin_y;
    logic            fin_c;
    logic            fin_eq;

    function automatic logic [XLEN-1:0] rf_read(input logic [IW-1:0] idx);
        return (idx == '0) ? '0 : rf_q[idx];
    endfunction

    assign rp_a_data  = rf_read(rp_a_idx);
    assign rp_b_data  = rf_read(rp_b_idx);
    assign req_ready  = (state_q == ST_IDLE);
    assign ld_ready   = (state_q != ST_WB);
    assign resp_valid = (state_q == ST_WB);
    assign shamt      = buf_q[BUF_B][SHW-1:0];

    pim_row_alu #(.XLEN(XLEN)) u_row_alu (
        .op   (alu_op),
        .a    (buf_q[BUF_A]),
        .b    (buf_q[BUF_B]),
        .cin  (alu_cin),
        .y    (alu_y),
        .cout (alu_cout)
    );

    // Per-cycle micro-op selection; SUB spends its first cycle inverting buf1
    always_comb begin
        alu_op    = ROW_AND;
        alu_cin   = 1'b0;
        exec_last = 1'b1;
        case (op_q)
            OP_OR:         alu_op = ROW_OR;
            OP_XOR, OP_EQ: alu_op = ROW_XOR;
            OP_ADD:        alu_op = ROW_ADD;
            OP_SUB: begin
                if (cnt_q == '0) begin
                    alu_op    = ROW_INV;
                    exec_last = 1'b0;
                end else begin
                    alu_op  = ROW_ADD;
                    alu_cin = 1'b1;
                end
            end
            OP_SLL: begin
                alu_op    = ROW_SLL;
                exec_last = (shamt == '0) || (cnt_q == shamt - SHW'(1));
            end
            OP_SRL: begin
                alu_op    = ROW_SRL;
                exec_last = (shamt == '0) || (cnt_q == shamt - SHW'(1));
            end
            default: ;
        endcase
    end

    always_comb begin
        fin_y  = alu_y;
        fin_c  = alu_cout;
        fin_eq = 1'b0;
        case (op_q)
            OP_LUI: begin
                fin_y = imm_q;
                fin_c = 1'b0;
            end
            OP_EQ: begin
                fin_eq = (alu_y == '0);
                fin_y  = {{(XLEN-1){1'b0}}, fin_eq};
                fin_c  = 1'b0;
            end
            OP_SLL, OP_SRL: begin
                if (shamt == '0) begin
                    fin_y = buf_q[BUF_A];
                    fin_c = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_EXEC;
            ST_EXEC: if (exec_last) state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            imm_sel_q   <= 1'b0;
            cnt_q       <= '0;
            resp_result <= '0;
            resp_carry  <= 1'b0;
            resp_eq     <= 1'b0;
            for (int i = 0; i < NBUF; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        rd_q      <= req_rd;
                        rs1_q     <= req_rs1;
                        rs2_q     <= req_rs2;
                        imm_q     <= req_imm;
                        imm_sel_q <= req_imm_sel;
                    end
                end
                // Operands snapshot pre-edge contents, so a same-cycle load is not seen
                ST_LOAD: begin
                    buf_q[BUF_A] <= rf_read(rs1_q);
                    buf_q[BUF_B] <= imm_sel_q ? imm_q : rf_read(rs2_q);
                    cnt_q        <= '0;
                end
                ST_EXEC: begin
                    cnt_q <= cnt_q + SHW'(1);
                    if (alu_op == ROW_INV) buf_q[BUF_B] <= alu_y;
                    else                   buf_q[BUF_A] <= fin_y;
                    if (exec_last) begin
                        resp_result <= fin_y;
                        resp_carry  <= fin_c;
                        resp_eq     <= fin_eq;
                    end
                end
                default: ;
            endcase
        end
    end

    // Op writeback and load writeback are exclusive: ld_ready is low in WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (state_q == ST_WB) begin
            if (op_q != OP_EQ && rd_q != '0) rf_q[rd_q] <= resp_result;
        end else if (ld_valid && ld_rd != '0) begin
            rf_q[ld_rd] <= ld_data;
        end
    end

endmodule

// File: tb/tb_pim_regfile_seq.sv
// Directed bench for pim_regfile_seq: hand-computed results, carries,
// latencies, handshake levels and reset behaviour.
module tb_pim_regfile_seq;
    import pim_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    pim_op_t     req_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        req_imm_sel;
    logic        resp_valid;
    logic [31:0] resp_result;
    logic        resp_carry;
    logic        resp_eq;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic [4:0]  rp_a_idx, rp_b_idx;
    logic [31:0] rp_a_data, rp_b_data;

    int checks = 0;
    int errors = 0;
    int lat, busy, rv;

    always #5 clk = ~clk;

    pim_regfile_seq dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rd      (req_rd),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_imm     (req_imm),
        .req_imm_sel (req_imm_sel),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .resp_carry  (resp_carry),
        .resp_eq     (resp_eq),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .rp_a_idx    (rp_a_idx),
        .rp_b_idx    (rp_b_idx),
        .rp_a_data   (rp_a_data),
        .rp_b_data   (rp_b_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        rp_a_idx = idx;
        rp_b_idx = idx;
        #1;
        chk({tag, "_a"}, rp_a_data, exp);
        chk({tag, "_b"}, rp_b_data, exp);
    endtask

    task automatic ld(input logic [4:0] rd, input logic [31:0] data);
        ld_valid = 1'b1;
        ld_rd    = rd;
        ld_data  = data;
        step();
        ld_valid = 1'b0;
    endtask

    // Issue one request from IDLE; returns at the WB-cycle negedge with the
    // latency (edges from acceptance to WB end) and cycles req_ready was high
    task automatic do_req(input pim_op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm, input logic sel,
                          input logic ldf, input logic [4:0] lrd, input logic [31:0] ldat,
                          output int l, output int b);
        req_op      = op;
        req_rd      = rd;
        req_rs1     = rs1;
        req_rs2     = rs2;
        req_imm     = imm;
        req_imm_sel = sel;
        req_valid   = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (ldf) begin
            ld_valid = 1'b1;
            ld_rd    = lrd;
            ld_data  = ldat;
        end
        l = 0;
        b = 0;
        while (l < 100) begin
            @(negedge clk);
            l++;
            if (l == 2) ld_valid = 1'b0;
            if (req_ready) b++;
            if (resp_valid) break;
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_op = OP_ADD; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        req_imm = '0; req_imm_sel = 1'b0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        rp_a_idx = '0; rp_b_idx = '0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_resp_carry", 32'(resp_carry), 32'd0);
        chk("rst_resp_eq", 32'(resp_eq), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rp_a_idx = i[4:0];
            rp_b_idx = 5'(31 - i);
            #1;
            chk("rst_read_a", rp_a_data, 32'd0);
            chk("rst_read_b", rp_b_data, 32'd0);
        end

        ld(5'd1, 32'h0000_0005);
        ld(5'd2, 32'h0000_0003);
        rd_chk("x1_init", 5'd1, 32'h5);
        rd_chk("x2_init", 5'd2, 32'h3);

        do_req(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, lat, busy);
        chk("sub1_lat", 32'(lat), 32'd4);
        chk("sub1_result", resp_result, 32'h2);
        chk("sub1_carry", 32'(resp_carry), 32'd1);
        chk("sub1_eq", 32'(resp_eq), 32'd0);
        chk("sub1_busy", 32'(busy), 32'd0);
        step();
        rd_chk("x3", 5'd3, 32'h2);

        do_req(OP_SUB, 5'd4, 5'd2, 5'd1, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, lat, busy);
        chk("sub2_result", resp_result, 32'hFFFF_FFFE);
        chk("sub2_carry", 32'(resp_carry), 32'd0);
        step();
        chk("sub2_valid_drop", 32'(resp_valid), 32'd0);
        chk("sub2_result_held", resp_result, 32'hFFFF_FFFE);
        rd_chk("x4", 5'd4, 32'hFFFF_FFFE);

        do_req(OP_ADD, 5'd5, 5'd1, 5'd0, 32'hFFFF_FFFB, 1'b1, 1'b0, 5'd0, 32'd0, lat, busy);
        chk("add_imm_lat", 32'(lat), 32'd3);
        chk("add_imm_result", resp_result, 32'h0);
        chk("add_imm_carry", 32'(resp_carry), 32'd1);
        step();
        rd_chk("x5", 5'd5, 32'h0);

        do_req(OP_ADD, 5'd0, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, lat, busy);
        chk("add_x0_result", resp_result, 32'h8);
        chk("add_x0_carry", 32'(resp_carry), 32'd0);
        step();
        rd_chk("x0", 5'd0, 32'h0);

        do_req(OP_SLL, 5'd6, 5'd1, 5'd0, 32'd31, 1'b1, 1'b0, 5'd0, 32'd0, lat, busy);
        chk("sll31_lat", 32'(lat), 32'd33);
        chk("sll31_result", resp_result, 32'h8000_0000);
        chk("sll31_carry", 32'(resp_carry), 32'd0);
        chk("sll31_busy", 32'(busy), 32'd0);
        step();
        rd_chk("x6", 5'd6, 32'h8000_0000);

        do_req(OP_SLL, 5'd8, 5'd1, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, lat, busy);
        chk("sll0_lat", 32'(lat), 32'd3);
        chk("sll0_result", resp_result, 32'h5);
        chk("sll0_carry", 32'(resp_carry), 32'd0);
        step();
        rd_chk("x8", 5'd8, 32'h5);

        do_req(OP_SRL, 5'd11, 5'd1, 5'd0, 32'd1, 1'b1, 1'b0, 5'd0, 32'd0, lat, busy);
        chk("srl1_lat", 32'(lat), 32'd3);
        chk("srl1_result", resp_result, 32'h2);
        chk("srl1_carry", 32'(resp_carry), 32'd1);
        step();
        rd_chk("x11", 5'd11, 32'h2);

        do_req(OP_LUI, 5'd12, 5'd1, 5'd0, 32'hDEAD_B000, 1'b1, 1'b0, 5'd0, 32'd0, lat, busy);
        chk("lui_result", resp_result, 32'hDEAD_B000);
        step();
        rd_chk("x12", 5'd12, 32'hDEAD_B000);

        do_req(OP_XOR, 5'd13, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, lat, busy);
        chk("xor_result", resp_result, 32'h6);
        chk("xor_eq", 32'(resp_eq), 32'd0);
        step();
        rd_chk("x13", 5'd13, 32'h6);

        do_req(OP_EQ, 5'd9, 5'd1, 5'd1, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, lat, busy);
        chk("eq_same", 32'(resp_eq), 32'd1);
        chk("eq_same_carry", 32'(resp_carry), 32'd0);
        step();
        rd_chk("x9_after_eq", 5'd9, 32'h0);
        rd_chk("x1_after_eq", 5'd1, 32'h5);

        do_req(OP_EQ, 5'd9, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, lat, busy);
        chk("eq_diff", 32'(resp_eq), 32'd0);
        step();

        do_req(OP_ADD, 5'd7, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 5'd1, 32'h0000_0100, lat, busy);
        chk("add_ldhit_lat", 32'(lat), 32'd3);
        chk("add_ldhit_result", resp_result, 32'h8);
        chk("wb_ld_ready", 32'(ld_ready), 32'd0);
        ld_valid = 1'b1;
        ld_rd    = 5'd14;
        ld_data  = 32'h0000_0055;
        step();
        rd_chk("x14_blocked", 5'd14, 32'h0);
        chk("post_wb_ld_ready", 32'(ld_ready), 32'd1);
        step();
        ld_valid = 1'b0;
        rd_chk("x14_retried", 5'd14, 32'h55);
        rd_chk("x7", 5'd7, 32'h8);
        rd_chk("x1_loaded", 5'd1, 32'h100);

        req_op = OP_SLL; req_rd = 5'd10; req_rs1 = 5'd1; req_rs2 = 5'd0;
        req_imm = 32'd31; req_imm_sel = 1'b1; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_ld_ready", 32'(ld_ready), 32'd1);
        chk("abort_resp_result", resp_result, 32'd0);
        chk("abort_resp_carry", 32'(resp_carry), 32'd0);
        chk("abort_resp_eq", 32'(resp_eq), 32'd0);
        step();
        rst = 1'b0;
        rv = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) rv++;
        end
        chk("abort_no_resp", 32'(rv), 32'd0);
        rd_chk("x10_abort", 5'd10, 32'h0);
        rd_chk("x1_abort", 5'd1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
